// File: rtl/ram_r1rw1_pkg.sv
// Shared definitions for the 1R/1RW RAM with power-up init sweep.
// State encoding for the init controller and the per-lane byte merge.
package ram_r1rw1_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int BYTE_W = 8;

  // One byte lane of a masked write: new byte when enabled, else old byte.
  function automatic logic [BYTE_W-1:0] byte_merge(
    input logic [BYTE_W-1:0] i_old,
    input logic [BYTE_W-1:0] i_new,
    input logic              i_en
  );
    return i_en ? i_new : i_old;
  endfunction

endpackage

// File: rtl/ram_r1rw1_core.sv
// Storage array for ram_r1rw1_init: asynchronous read ports at the read
// address and at the write address, one byte-masked write port. No reset;
// contents are defined only by the init sweep in the top.
module ram_r1rw1_core
  import ram_r1rw1_pkg::*;
#(
  parameter int A = 9,
  parameter int D = 64
) (
  input  logic             Clk,
  input  logic             i_we,
  input  logic [D/8-1:0]   i_be,
  input  logic [A-1:0]     i_waddr,
  input  logic [D-1:0]     i_wdata,
  input  logic [A-1:0]     i_raddr,
  output logic [D-1:0]     o_rdata,
  output logic [D-1:0]     o_wold
);

  localparam int NB = D / 8;

  logic [D-1:0] r_mem [2**A];
  logic [D-1:0] w_merged;

  assign o_rdata = r_mem[i_raddr];
  assign o_wold  = r_mem[i_waddr];

  for (genvar g = 0; g < NB; g++) begin : g_lane
    assign w_merged[BYTE_W*g +: BYTE_W] =
      byte_merge(o_wold[BYTE_W*g +: BYTE_W], i_wdata[BYTE_W*g +: BYTE_W], i_be[g]);
  end

  // Whole-word write of the lane-merged value; disabled lanes rewrite old data.
  always_ff @(posedge Clk) begin
    if (i_we) r_mem[i_waddr] <= w_merged;
  end

endmodule

// File: rtl/ram_r1rw1_init.sv
// 1R/1RW RAM that fills itself with INIT_VAL after reset, then serves a read
// port and a read-modify-write port with L-cycle latency (L = 1 or 2).
// Optional macro RAM_R1RW1_BYPASS_EN: same-cycle same-address read returns the
// merged write data (write-first); otherwise the read returns the old word.
module ram_r1rw1_init
  import ram_r1rw1_pkg::*;
#(
  parameter int             A        = 9,
  parameter int             D        = 64,
  parameter int             L        = 1,
  parameter logic [D-1:0]   INIT_VAL = '0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             WrEnb,
  input  logic [D/8-1:0]   WrByteEnb,
  input  logic [A-1:0]     WrAddr,
  input  logic [D-1:0]     WrData,
  output logic [D-1:0]     WrDataOut,
  input  logic             RdEnb,
  input  logic [A-1:0]     RdAddr,
  output logic [D-1:0]     RdData,
  output logic             RdValid,
  output logic             InitDone
);

  localparam int NB = D / 8;

  state_e          r_state, w_state_nxt;
  logic [A:0]      r_ptr;
  logic [A:0]      w_ptr_nxt;
  logic            w_ready, w_rd_acc, w_wr_acc;
  logic            w_core_we;
  logic [NB-1:0]   w_core_be;
  logic [A-1:0]    w_core_waddr;
  logic [D-1:0]    w_core_wdata;
  logic [D-1:0]    w_rd_old, w_wr_old, w_rd_word;

  // Extra pointer bit flags the end of the sweep without wrapping to 0.
  assign w_ptr_nxt = r_ptr + (A+1)'(1);

  // State register and sweep pointer.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= ST_INIT;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT) r_ptr <= w_ptr_nxt;
    end
  end

  // Next state: leave INIT once the last address is being written.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_INIT && w_ptr_nxt[A]) w_state_nxt = ST_READY;
  end

  // Outputs of the FSM: core write port muxes between sweep and user writes.
  always_comb begin
    w_ready      = (r_state == ST_READY);
    w_core_we    = 1'b1;
    w_core_be    = '1;
    w_core_waddr = r_ptr[A-1:0];
    w_core_wdata = INIT_VAL;
    if (w_ready) begin
      w_core_we    = WrEnb;
      w_core_be    = WrByteEnb;
      w_core_waddr = WrAddr;
      w_core_wdata = WrData;
    end
    if (Rst) w_core_we = 1'b0;
  end

  assign InitDone = w_ready;
  assign w_rd_acc = w_ready & RdEnb & ~Rst;
  assign w_wr_acc = w_ready & WrEnb & ~Rst;

  ram_r1rw1_core #(.A(A), .D(D)) u_core (
    .Clk     (Clk),
    .i_we    (w_core_we),
    .i_be    (w_core_be),
    .i_waddr (w_core_waddr),
    .i_wdata (w_core_wdata),
    .i_raddr (RdAddr),
    .o_rdata (w_rd_old),
    .o_wold  (w_wr_old)
  );

`ifdef RAM_R1RW1_BYPASS_EN
  logic [D-1:0] w_byp_word;
  for (genvar g = 0; g < NB; g++) begin : g_byp
    assign w_byp_word[BYTE_W*g +: BYTE_W] =
      byte_merge(w_rd_old[BYTE_W*g +: BYTE_W], WrData[BYTE_W*g +: BYTE_W], WrByteEnb[g]);
  end
  assign w_rd_word = (w_wr_acc && (WrAddr == RdAddr)) ? w_byp_word : w_rd_old;
`else
  assign w_rd_word = w_rd_old;
`endif

  logic [L:1]   r_rd_vld_pipe, r_wr_vld_pipe;
  logic [D-1:0] r_rd_dat [1:L];
  logic [D-1:0] r_wr_dat [1:L];

  // Latency pipeline; data only moves with its valid so the last stage holds.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_rd_vld_pipe <= '0;
      r_wr_vld_pipe <= '0;
      for (int i = 1; i <= L; i++) begin
        r_rd_dat[i] <= '0;
        r_wr_dat[i] <= '0;
      end
    end else begin
      r_rd_vld_pipe[1] <= w_rd_acc;
      r_wr_vld_pipe[1] <= w_wr_acc;
      if (w_rd_acc) r_rd_dat[1] <= w_rd_word;
      if (w_wr_acc) r_wr_dat[1] <= w_wr_old;
      for (int i = 2; i <= L; i++) begin
        r_rd_vld_pipe[i] <= r_rd_vld_pipe[i-1];
        r_wr_vld_pipe[i] <= r_wr_vld_pipe[i-1];
        if (r_rd_vld_pipe[i-1]) r_rd_dat[i] <= r_rd_dat[i-1];
        if (r_wr_vld_pipe[i-1]) r_wr_dat[i] <= r_wr_dat[i-1];
      end
    end
  end

  assign RdData    = r_rd_dat[L];
  assign RdValid   = r_rd_vld_pipe[L];
  assign WrDataOut = r_wr_dat[L];

endmodule

// File: tb/tb_ram_r1rw1_init.sv
// Bench for ram_r1rw1_init: one L=1 and one L=2 instance share inputs and are
// checked every cycle against an array-based model of the memory.
module tb_ram_r1rw1_init;

  localparam logic [63:0] IV = 64'hA5A5A5A5A5A5A5A5;
`ifdef RAM_R1RW1_BYPASS_EN
  localparam bit          BYP   = 1'b1;
  localparam logic [63:0] COLL1 = 64'hDEADBEEFDEADBEEF;
  localparam logic [63:0] COLL2 = 64'hFEDCBA9889ABCDEF;
`else
  localparam bit          BYP   = 1'b0;
  localparam logic [63:0] COLL1 = 64'h0;
  localparam logic [63:0] COLL2 = 64'h0123456789ABCDEF;
`endif

  logic        clk = 1'b0;
  logic        Rst = 1'b1, WrEnb = 1'b0, RdEnb = 1'b0;
  logic [7:0]  WrByteEnb = '0;
  logic [3:0]  WrAddr = '0, RdAddr = '0;
  logic [63:0] WrData = '0;
  logic [63:0] rd1, wo1, rd2, wo2;
  logic        rv1, id1, rv2, id2;

  always #5 clk = ~clk;

  ram_r1rw1_init #(.A(4), .D(64), .L(1), .INIT_VAL(IV)) dut1 (
    .Clk(clk), .Rst(Rst), .WrEnb(WrEnb), .WrByteEnb(WrByteEnb), .WrAddr(WrAddr),
    .WrData(WrData), .WrDataOut(wo1), .RdEnb(RdEnb), .RdAddr(RdAddr),
    .RdData(rd1), .RdValid(rv1), .InitDone(id1));

  ram_r1rw1_init #(.A(4), .D(64), .L(2), .INIT_VAL(IV)) dut2 (
    .Clk(clk), .Rst(Rst), .WrEnb(WrEnb), .WrByteEnb(WrByteEnb), .WrAddr(WrAddr),
    .WrData(WrData), .WrDataOut(wo2), .RdEnb(RdEnb), .RdAddr(RdAddr),
    .RdData(rd2), .RdValid(rv2), .InitDone(id2));

  int total = 0, bad = 0;

  typedef struct {
    bit          rst, acc, wacc;
    logic [63:0] word, wold;
  } hist_t;

  logic [63:0] m_mem [16];
  bit          m_ready = 1'b0;
  int          m_sweep = 0;
  hist_t       hp = '{default: 0};
  bit          e1v = 0, e2v = 0;
  logic [63:0] e1d = '0, e1w = '0, e2d = '0, e2w = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // One clock: apply inputs, advance the model, compare both instances.
  task automatic step(input bit rst, input bit we, input logic [7:0] be,
                      input logic [3:0] wa, input logic [63:0] wd,
                      input bit re, input logic [3:0] ra);
    hist_t       h;
    logic [63:0] nv;
    @(negedge clk);
    Rst = rst; WrEnb = we; WrByteEnb = be; WrAddr = wa; WrData = wd;
    RdEnb = re; RdAddr = ra;
    h = '{default: 0};
    h.rst = rst;
    if (rst) begin
      m_ready = 1'b0;
      m_sweep = 0;
    end else if (!m_ready) begin
      m_mem[m_sweep] = IV;
      m_sweep++;
      if (m_sweep == 16) m_ready = 1'b1;
    end else begin
      nv = m_mem[wa];
      for (int b = 0; b < 8; b++) if (be[b]) nv[8*b +: 8] = wd[8*b +: 8];
      h.acc  = re;
      h.word = (BYP && we && wa == ra) ? nv : m_mem[ra];
      h.wacc = we;
      h.wold = m_mem[wa];
      if (we) m_mem[wa] = nv;
    end
    if (rst) begin
      e1v = 0; e1d = '0; e1w = '0; e2v = 0; e2d = '0; e2w = '0;
    end else begin
      e1v = h.acc;  if (h.acc)  e1d = h.word; if (h.wacc)  e1w = h.wold;
      e2v = hp.acc; if (hp.acc) e2d = hp.word; if (hp.wacc) e2w = hp.wold;
    end
    hp = h;
    @(posedge clk); #1;
    chk("L1.RdValid",   64'(rv1), 64'(e1v));
    chk("L1.RdData",    rd1, e1d);
    chk("L1.WrDataOut", wo1, e1w);
    chk("L1.InitDone",  64'(id1), 64'(m_ready));
    chk("L2.RdValid",   64'(rv2), 64'(e2v));
    chk("L2.RdData",    rd2, e2d);
    chk("L2.WrDataOut", wo2, e2w);
    chk("L2.InitDone",  64'(id2), 64'(m_ready));
  endtask

  // Reset for one cycle, then count cycles until InitDone rises (reads issued throughout).
  task automatic init_seq();
    int n;
    n = 0;
    step(1, 0, 8'h00, 4'd0, 64'h0, 1, 4'd0);
    for (int i = 1; i <= 40 && n == 0; i++) begin
      step(0, 1, 8'hFF, 4'(i), 64'h0, 1, 4'(i));
      if (id1) n = i;
    end
    chk("init_cycles", 64'(n), 64'd16);
  endtask

  typedef struct {
    bit          we;
    logic [7:0]  be;
    logic [3:0]  wa;
    logic [63:0] wd;
    bit          re;
    logic [3:0]  ra;
    bit          ev;
    logic [63:0] erd;
    logic [63:0] ewo;
  } vec_t;

  vec_t tbl [10];

  logic [3:0]  r_wa, r_ra;
  logic [7:0]  r_be;
  logic [63:0] r_wd;

  initial begin
    tbl[0] = '{1, 8'hFF, 4'd3, 64'h1122334455667788, 0, 4'd0, 0, 64'h0, IV};
    tbl[1] = '{1, 8'h0F, 4'd3, 64'hFFFFFFFFFFFFFFFF, 0, 4'd0, 0, 64'h0, 64'h1122334455667788};
    tbl[2] = '{0, 8'h00, 4'd0, 64'h0, 1, 4'd3, 1, 64'h11223344FFFFFFFF, 64'h0};
    tbl[3] = '{1, 8'hFF, 4'd5, 64'h0, 0, 4'd0, 0, 64'h0, IV};
    tbl[4] = '{1, 8'hFF, 4'd5, 64'hDEADBEEFDEADBEEF, 1, 4'd5, 1, COLL1, 64'h0};
    tbl[5] = '{0, 8'h00, 4'd0, 64'h0, 1, 4'd5, 1, 64'hDEADBEEFDEADBEEF, 64'h0};
    tbl[6] = '{1, 8'h00, 4'd3, 64'h0, 0, 4'd0, 0, 64'h0, 64'h11223344FFFFFFFF};
    tbl[7] = '{0, 8'h00, 4'd0, 64'h0, 1, 4'd3, 1, 64'h11223344FFFFFFFF, 64'h0};
    tbl[8] = '{1, 8'hFF, 4'd9, 64'h0123456789ABCDEF, 1, 4'd2, 1, IV, IV};
    tbl[9] = '{1, 8'hF0, 4'd9, 64'hFEDCBA9876543210, 1, 4'd9, 1, COLL2, 64'h0123456789ABCDEF};

    // Reset state and first init sweep.
    step(1, 0, 8'h00, 4'd0, 64'h0, 0, 4'd0);
    init_seq();

    // Every address holds INIT_VAL after the sweep.
    for (int a = 0; a < 16; a++) begin
      step(0, 0, 8'h00, 4'd0, 64'h0, 1, 4'(a));
      chk("init_readback", rd1, IV);
    end
    step(0, 0, 8'h00, 4'd0, 64'h0, 0, 4'd0);

    // Directed vectors: byte-masked RMW, collisions, empty byte mask.
    for (int i = 0; i < 10; i++) begin
      step(0, tbl[i].we, tbl[i].be, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra);
      chk($sformatf("tbl%0d.RdValid", i), 64'(rv1), 64'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("tbl%0d.RdData", i), rd1, tbl[i].erd);
      if (tbl[i].we) chk($sformatf("tbl%0d.WrDataOut", i), wo1, tbl[i].ewo);
    end

    // Reset at sweep address 7 restarts the sweep.
    step(1, 0, 8'h00, 4'd0, 64'h0, 1, 4'd0);
    for (int i = 0; i < 7; i++) step(0, 1, 8'hFF, 4'd1, 64'h0, 1, 4'(i));
    chk("mid_sweep_initdone", 64'(id1), 64'd0);
    init_seq();

    // Back-to-back reads 0..7, then reset mid-stream kills in-flight reads.
    for (int a = 0; a < 8; a++) begin
      step(0, 0, 8'h00, 4'd0, 64'h0, 1, 4'(a));
      if (a >= 1) chk("stream_L2_valid", 64'(rv2), 64'd1);
    end
    step(1, 0, 8'h00, 4'd0, 64'h0, 1, 4'd0);
    chk("rst_L2_valid", 64'(rv2), 64'd0);
    step(0, 0, 8'h00, 4'd0, 64'h0, 1, 4'd0);
    chk("post_rst_L2_valid", 64'(rv2), 64'd0);

    // Random traffic with collisions and occasional resets.
    for (int k = 0; k < 600; k++) begin
      r_wa = 4'($urandom_range(0, 15));
      r_ra = ($urandom_range(0, 1) == 0) ? r_wa : 4'($urandom_range(0, 15));
      r_be = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      r_wd = {$urandom, $urandom};
      step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, r_be, r_wa, r_wd,
           $urandom_range(0, 2) != 0, r_ra);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
